// File: rtl/uart_rx_if.sv
// ============================================================================
//  Module      : uart_rx_if
//  Description : Line-side and bus-side signal bundle of the UART receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_if;
   logic       sample_tick;
   logic       en;
   logic       chk_en;
   logic       rxd;
   logic [7:0] dat;
   logic       dat_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;
   logic       rint;

   // The receiver itself
   modport slave (
      input  sample_tick,
      input  en,
      input  chk_en,
      input  rxd,
      output dat,
      output dat_valid,
      output parity_err,
      output frame_err,
      output busy,
      output rint
   );

   // Whoever drives the line/controls and consumes received bytes
   modport master (
      output sample_tick,
      output en,
      output chk_en,
      output rxd,
      input  dat,
      input  dat_valid,
      input  parity_err,
      input  frame_err,
      input  busy,
      input  rint
   );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver, 8 data bits, optional odd parity,
//                one stop bit. Define UART_RX_MAJORITY_EN for 2-of-3 voting.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx #(
   parameter int OVS = 16,
   parameter int CW  = 4
) (
   input  wire logic clk,
   input  wire logic rst,
   uart_rx_if.slave  bus
);

   generate
      if (OVS < 4 || OVS > 16 || (OVS % 2) != 0 || (2 ** CW) < OVS) begin : g_bad_param
         $error("uart_rx: OVS must be even in 4..16 and fit in CW bits");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nxt;
   logic [2:0]      r_bit;
   logic [2:0]      w_bit_nxt;
   logic [7:0]      r_shreg;
   logic [7:0]      w_shreg_nxt;
   logic            r_par;
   logic            w_par_nxt;
   logic            r_armed;
   logic            w_armed_nxt;
   logic            r_chk_l;
   logic            w_chk_l_nxt;
   logic [7:0]      r_dat;
   logic [7:0]      w_dat_nxt;
   logic            r_dv;
   logic            w_dv_nxt;
   logic            r_pe;
   logic            w_pe_nxt;
   logic            r_fe;
   logic            w_fe_nxt;
   logic [1:0]      r_sync;
   logic            w_rxd_s;
   logic            w_samp;

   assign w_rxd_s = r_sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], bus.rxd};
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // Voting window is P-1..P+1 with the decision at P+1. Delaying the START
   // decision by one tick shifts every later window by one, so the bit
   // decision stays at OVS-1 and bit spacing stays exactly OVS ticks.
   localparam logic [CW-1:0] c_start_dec = CW'(OVS / 2);
   localparam logic [CW-1:0] c_bit_dec   = CW'(OVS - 1);

   logic [1:0] r_hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_hist <= 2'b11;
      end else if (bus.sample_tick) begin
         r_hist <= {r_hist[0], w_rxd_s};
      end
   end

   assign w_samp = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_rxd_s) | (r_hist[0] & w_rxd_s);
`else
   localparam logic [CW-1:0] c_start_dec = CW'(OVS / 2 - 1);
   localparam logic [CW-1:0] c_bit_dec   = CW'(OVS - 1);

   assign w_samp = w_rxd_s;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shreg <= '0;
         r_par   <= 1'b0;
         r_armed <= 1'b0;
         r_chk_l <= 1'b0;
         r_dat   <= '0;
         r_dv    <= 1'b0;
         r_pe    <= 1'b0;
         r_fe    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shreg <= w_shreg_nxt;
         r_par   <= w_par_nxt;
         r_armed <= w_armed_nxt;
         r_chk_l <= w_chk_l_nxt;
         r_dat   <= w_dat_nxt;
         r_dv    <= w_dv_nxt;
         r_pe    <= w_pe_nxt;
         r_fe    <= w_fe_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shreg_nxt = r_shreg;
      w_par_nxt   = r_par;
      w_armed_nxt = r_armed;
      w_chk_l_nxt = r_chk_l;
      w_dat_nxt   = r_dat;
      w_dv_nxt    = 1'b0;
      w_pe_nxt    = r_pe;
      w_fe_nxt    = r_fe;

      if (r_state != S_IDLE && !bus.en) begin
         // Abort ignores the tick; armed is dropped so a fresh idle-high is needed
         w_state_nxt = S_IDLE;
         w_cnt_nxt   = '0;
         w_armed_nxt = 1'b0;
      end else if (bus.sample_tick) begin
         case (r_state)
            S_IDLE: begin
               if (w_rxd_s) begin
                  w_armed_nxt = 1'b1;
               end
               if (bus.en && r_armed && !w_rxd_s) begin
                  w_state_nxt = S_START;
                  w_cnt_nxt   = '0;
                  w_chk_l_nxt = bus.chk_en;
               end
            end
            S_START: begin
               if (r_cnt == c_start_dec) begin
                  w_cnt_nxt = '0;
                  w_bit_nxt = '0;
                  w_state_nxt = w_samp ? S_IDLE : S_DATA;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_DATA: begin
               if (r_cnt == c_bit_dec) begin
                  w_cnt_nxt   = '0;
                  w_shreg_nxt = {w_samp, r_shreg[7:1]};
                  w_bit_nxt   = r_bit + 3'd1;
                  if (r_bit == 3'd7) begin
                     w_state_nxt = r_chk_l ? S_PARITY : S_STOP;
                  end
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_PARITY: begin
               if (r_cnt == c_bit_dec) begin
                  w_cnt_nxt   = '0;
                  w_par_nxt   = w_samp;
                  w_state_nxt = S_STOP;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (r_cnt == c_bit_dec) begin
                  w_cnt_nxt   = '0;
                  w_dat_nxt   = r_shreg;
                  w_dv_nxt    = 1'b1;
                  w_fe_nxt    = ~w_samp;
                  w_pe_nxt    = r_chk_l & ~(^{r_par, r_shreg});
                  w_armed_nxt = w_samp;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CW'(1);
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign bus.dat        = r_dat;
   assign bus.dat_valid  = r_dv;
   assign bus.rint       = r_dv;
   assign bus.parity_err = r_pe;
   assign bus.frame_err  = r_fe;
   assign bus.busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed and random frames scored against
// a frame-level reference model (byte, odd-parity rule, stop-bit rule).
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;
   localparam int OVS = 16;
   localparam int CW  = 4;

   logic clk = 1'b0;
   logic rst;

   uart_rx_if rx_if();

   uart_rx #(.OVS(OVS), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (rx_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       ri;
   } rec_t;

   rec_t exp_q[$];
   rec_t obs_q[$];
   int   total = 0;
   int   bad   = 0;

   always @(negedge clk) begin
      if (rx_if.dat_valid) begin
         obs_q.push_back('{rx_if.dat, rx_if.parity_err, rx_if.frame_err, rx_if.rint});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Frame-level model: odd parity means data plus parity bit hold an odd count of 1s
   function automatic rec_t model(input logic [7:0] d, input bit par_on, input bit par_bit, input bit stop_bit);
      rec_t r;
      int   ones;
      ones = $countones(d) + int'(par_bit);
      r.d  = d;
      r.pe = par_on && ((ones % 2) == 0);
      r.fe = !stop_bit;
      r.ri = 1'b1;
      return r;
   endfunction

   task automatic hold(input logic v, input int n);
      rx_if.rxd = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input bit par_on, input bit par_bit, input bit stop_bit);
      rx_if.chk_en = par_on;
      hold(1'b0, OVS);
      // Receiver latched chk_en during the start bit; wiggling it now must not matter
      rx_if.chk_en = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) hold(d[i], OVS);
      if (par_on) hold(par_bit, OVS);
      hold(stop_bit, OVS);
   endtask

   task automatic expect_frame(input logic [7:0] d, input bit par_on, input bit par_bit, input bit stop_bit);
      exp_q.push_back(model(d, par_on, par_bit, stop_bit));
      send(d, par_on, par_bit, stop_bit);
   endtask

   task automatic settle(input string tag);
      int n;
      int m;
      n = 0;
      while (obs_q.size() < exp_q.size() && n < 400) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         chk($sformatf("%s_dat%0d", tag, i), 32'(obs_q[i].d),  32'(exp_q[i].d));
         chk($sformatf("%s_pe%0d",  tag, i), 32'(obs_q[i].pe), 32'(exp_q[i].pe));
         chk($sformatf("%s_fe%0d",  tag, i), 32'(obs_q[i].fe), 32'(exp_q[i].fe));
         chk($sformatf("%s_ri%0d",  tag, i), 32'(obs_q[i].ri), 32'(exp_q[i].ri));
      end
      obs_q.delete();
      exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_dat"},  32'(rx_if.dat),        32'h0);
      chk({tag, "_dv"},   32'(rx_if.dat_valid),  32'h0);
      chk({tag, "_pe"},   32'(rx_if.parity_err), 32'h0);
      chk({tag, "_fe"},   32'(rx_if.frame_err),  32'h0);
      chk({tag, "_busy"}, 32'(rx_if.busy),       32'h0);
      chk({tag, "_rint"}, 32'(rx_if.rint),       32'h0);
   endtask

   initial begin
      logic [7:0] d;
      bit         p_on;
      bit         p_b;
      bit         s_b;

      rst               = 1'b1;
      rx_if.rxd         = 1'b1;
      rx_if.sample_tick = 1'b1;
      rx_if.en          = 1'b1;
      rx_if.chk_en      = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold(1'b1, 20);

      expect_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      hold(1'b1, 4);
      settle("a5");
      chk("a5_busy_after", 32'(rx_if.busy), 32'h0);

      expect_frame(8'h3C, 1'b1, 1'b1, 1'b1);
      hold(1'b1, 4);
      settle("3c_par1");
      expect_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      hold(1'b1, 4);
      settle("3c_par0");

      // Short low pulse: rejected at the start-bit midpoint
      hold(1'b0, 4);
      chk("glitch_busy_high", 32'(rx_if.busy), 32'h1);
      hold(1'b1, 30);
      chk("glitch_busy_low", 32'(rx_if.busy), 32'h0);
      settle("glitch");

      // Line break from idle: one all-zero frame with a framing error only
      exp_q.push_back(model(8'h00, 1'b0, 1'b0, 1'b0));
      rx_if.chk_en = 1'b0;
      hold(1'b0, 250);
      hold(1'b1, 20);
      settle("break0");

      expect_frame(8'h55, 1'b0, 1'b0, 1'b0);
      hold(1'b0, 200);
      settle("stop0_hold");
      hold(1'b1, 20);
      expect_frame(8'h12, 1'b0, 1'b0, 1'b1);
      hold(1'b1, 4);
      settle("12");

      // Reset in the middle of data bit 3
      d = 8'h6B;
      rx_if.chk_en = 1'b0;
      hold(1'b0, OVS);
      for (int i = 0; i < 3; i++) hold(d[i], OVS);
      hold(d[3], OVS / 2);
      rst = 1'b1;
      @(negedge clk);
      check_reset("rst_mid");
      @(posedge clk);
      #1;
      rst = 1'b0;
      hold(1'b1, 20);
      settle("rst_nodv");
      expect_frame(8'hFF, 1'b0, 1'b0, 1'b1);
      hold(1'b1, 4);
      settle("ff");

      // Back-to-back frames, then a third frame aborted by en
      expect_frame(8'h01, 1'b0, 1'b0, 1'b1);
      expect_frame(8'h80, 1'b0, 1'b0, 1'b1);
      hold(1'b0, OVS);
      hold(1'b1, OVS);
      hold(1'b0, OVS / 2);
      chk("abort_busy_before", 32'(rx_if.busy), 32'h1);
      rx_if.en = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_busy_after", 32'(rx_if.busy), 32'h0);
      hold(1'b1, 30);
      rx_if.en = 1'b1;
      hold(1'b1, 40);
      settle("b2b_abort");

      for (int k = 0; k < 10; k++) begin
         d    = 8'($urandom);
         p_on = 1'($urandom_range(0, 1));
         p_b  = 1'($urandom_range(0, 1));
         s_b  = ($urandom_range(0, 3) != 0);
         expect_frame(d, p_on, p_b, s_b);
         hold(1'b1, $urandom_range(4, 30));
         settle($sformatf("rnd%0d", k));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver paired with the team's UART transmitter. It consumes the TxD line: 1 start bit, 8 data bits LSB-first, optional odd-parity bit, 1 stop bit.
- Oversamples the line using a sample strobe and validates the start bit mid-bit.
- Delivers each byte with a one-cycle valid pulse, parity/framing status and an interrupt pulse to the bus-side register block.

Parameters:
- OVS, 16, sample strobes per bit; even, 4..16.
- CW, 4, width of the sample counter; must satisfy 2^CW >= OVS.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- sample_tick  in  1  oversampling strobe, one clk wide, OVS per bit period
- en  in  1  receiver enable
- chk_en  in  1  parity bit present and checked
- rxd  in  1  serial line, asynchronous, idle high
- dat  out  8  last received byte
- dat_valid  out  1  one-cycle pulse: dat and status updated
- parity_err  out  1  parity mismatch on last frame
- frame_err  out  1  stop bit sampled low on last frame
- busy  out  1  frame reception in progress
- rint  out  1  receive interrupt pulse, coincident with dat_valid

Behaviour:
- Reset values:
  - dat=0, dat_valid=0, parity_err=0, frame_err=0, busy=0, rint=0.
  - Synchronizer flops=1, state=IDLE, cnt=0, armed=0.
- rxd passes through a 2-flop synchronizer to give rxd_s. All decisions use rxd_s and occur only on clk edges with sample_tick=1.
- busy=1 in every state except IDLE.
- IDLE:
  - armed is set when rxd_s=1.
  - On a tick with en=1, armed=1 and rxd_s=0: go to START, cnt=0, latch chk_en into chk_l.
- START:
  - cnt increments per tick.
  - At the tick where cnt==OVS/2-1, sample. rxd_s=0 means go to DATA with cnt=0 and bit index=0. rxd_s=1 means a glitch: return to IDLE with no output.
- DATA:
  - Sample at the tick where cnt==OVS-1, then cnt=0.
  - Shift the sample into shreg[7] (LSB-first arrival).
  - After bit 7 go to PARITY if chk_l=1, else to STOP.
- PARITY: sample at cnt==OVS-1 into par.
- STOP: sample at cnt==OVS-1. On the same clk edge:
  - dat<=shreg; dat_valid<=1 and rint<=1 for exactly one clk.
  - frame_err<=~rxd_s.
  - parity_err<=chk_l & ~(^{par,shreg}) (odd parity: data plus parity bit must hold an odd number of 1s).
  - armed<=rxd_s; next state IDLE.
- Status bits hold until the next dat_valid.
- Latency: dat_valid asserts on the tick at the middle of the stop bit, about 9.5 (no parity) or 10.5 (parity) bit times after the start edge, plus 2 clk of synchronizer delay.
- A break (line held low) produces one frame with frame_err=1 and dat=0. No new frame starts until rxd_s has been high on at least one tick (armed).
- en=0 in any non-IDLE state aborts to IDLE on the next clk, regardless of tick. There is no dat_valid, status is unchanged and armed is cleared.
- A chk_en change mid-frame is ignored (chk_l is used).
- rst mid-frame returns everything to its reset values immediately.
- sample_tick=0: state and counters hold.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each sample point uses a 2-of-3 majority of rxd_s taken at ticks cnt==P-1, P and P+1, where P is the nominal sample count (OVS/2-1 in START, OVS-1 elsewhere). The decision is taken at tick P+1, and the next bit's count is offset so that bit spacing stays exactly OVS ticks.
- Undefined: single sample at tick P, as described above.

Test Plan:
All scenarios use OVS=16 with sample_tick tied to 1.
- Frame 0xA5, chk_en=0, 16 clk/bit -> one dat_valid pulse with dat=0xA5, parity_err=0, frame_err=0, rint coincident; busy low after the pulse.
- Frame 0x3C, chk_en=1, parity bit 1 -> dat=0x3C, parity_err=0. Repeat with parity bit 0 -> dat=0x3C, parity_err=1.
- rxd low for 4 clk, then high -> busy rises, then returns to IDLE at the START sample; no dat_valid.
- Frame 0x55 with stop bit 0, then line held low for 200 clk -> exactly one dat_valid with frame_err=1. A valid 0x12 frame sent after the line goes high -> dat=0x12, frame_err=0.
- Assert rst during bit 3 of a frame -> all outputs at reset values next cycle. A following frame 0xFF is received correctly.
- Back-to-back frames 0x01, 0x80 with no idle gap, then en dropped mid-frame on a third frame -> two dat_valid pulses (0x01, 0x80) and none for the aborted frame.
